vga_pixel_fetch: RTL and testbench

- Upstream feeder for the VGA controller: streams packed 24-bit RGB pixels from external SRAM and presents one pixel per active VGA position on oRed/oGreen/oBlue.
- Its coordinate inputs connect to the controller's oCoord_X/oCoord_Y.
- A read FSM issues SRAM reads ahead of the display through a small pixel FIFO.
- The controller's blanking logic forces black outside the active window independently.

---
 rtl/vga_pixel_fetch_if.sv | 21 ++
 rtl/vga_pixel_fetch.sv | 80 ++++++++
 tb/tb_vga_pixel_fetch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_pixel_fetch_if.sv
// vga_pixel_fetch_if: VGA coordinate, SRAM read and RGB pixel signals of the pixel fetcher
interface vga_pixel_fetch_if;
  logic        Enable;
  logic [9:0]  iCoord_X;
  logic [9:0]  iCoord_Y;
  logic [17:0] oSRAM_address;
  logic        oSRAM_re;
  logic [15:0] iSRAM_read_data;
  logic [7:0]  oRed;
  logic [7:0]  oGreen;
  logic [7:0]  oBlue;
  logic        oUnderflow;
  modport slave (
    input  Enable, iCoord_X, iCoord_Y, iSRAM_read_data,
    output oSRAM_address, oSRAM_re, oRed, oGreen, oBlue, oUnderflow
  );
  modport master (
    output Enable, iCoord_X, iCoord_Y, iSRAM_read_data,
    input  oSRAM_address, oSRAM_re, oRed, oGreen, oBlue, oUnderflow
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: streams 3-words-per-2-pixels RGB from SRAM through a small FIFO to the VGA controller
module vga_pixel_fetch #(
  parameter int          H_ACT      = 320,
  parameter int          V_ACT      = 240,
  parameter logic [17:0] BASE_ADDR  = 18'd0,
  parameter int          RD_LAT     = 2,
  parameter int          FIFO_DEPTH = 8
) (
  input logic Clock,
  input logic Reset,
  vga_pixel_fetch_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [18:0] END_ADDR = 19'(BASE_ADDR) + 19'(3 * H_ACT * V_ACT / 2);
  localparam logic [CW:0] LIMIT = (CW + 1)'(FIFO_DEPTH - 2);
  typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;
  state_t r_state, w_next;
  logic [17:0] r_addr;
  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, r_fly;
  logic [RD_LAT-1:0] r_vld;
  logic [1:0] r_idx [RD_LAT];
  logic [7:0] r_r0, r_g0, r_r1;
  logic r_unf;
  logic w_active, w_restart, w_take, w_pop, w_push, w_go;
  logic [1:0] w_idx;
  logic [15:0] w_d;
  logic [18:0] w_naddr;
  logic [23:0] w_pix;
  assign w_d = bus.iSRAM_read_data;
  assign w_active = (bus.iCoord_X < 10'(H_ACT)) && (bus.iCoord_Y < 10'(V_ACT));
  assign w_restart = bus.Enable && bus.iCoord_X == 10'd0 && bus.iCoord_Y == 10'(V_ACT);
  assign w_take = bus.Enable && w_active;
  assign w_pop = w_take && r_cnt != '0;
  assign w_push = r_vld[RD_LAT-1] && r_idx[RD_LAT-1] != 2'd0;
  assign w_pix = r_idx[RD_LAT-1] == 2'd1 ? {r_r0, r_g0, w_d[15:8]} : {r_r1, w_d};
  assign w_idx = 2'(r_state) - 2'd1;
  // the next read's address decides whether another 3-word group is still needed
  assign w_naddr = {1'b0, r_addr} + 19'(r_state != S_IDLE);
  assign w_go = w_naddr < END_ADDR && ({1'b0, r_cnt} + {1'b0, r_fly}) <= LIMIT;
  assign bus.oSRAM_re = r_state != S_IDLE;
  assign bus.oSRAM_address = r_addr;
  assign {bus.oRed, bus.oGreen, bus.oBlue} = r_cnt != '0 ? r_mem[r_rp] : 24'd0;
  assign bus.oUnderflow = r_unf;
  always_comb
    w_next = w_restart ? S_IDLE : r_state == S_W0 ? S_W1 : r_state == S_W1 ? S_W2 : w_go ? S_W0 : S_IDLE;
  always_ff @(posedge Clock)
    r_state <= Reset ? S_IDLE : w_next;
  always_ff @(posedge Clock) begin
    if (Reset || w_restart) begin
      r_addr <= BASE_ADDR;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_fly  <= '0;
      r_vld  <= '0;
    end else begin
      if (bus.oSRAM_re) r_addr <= r_addr + 18'd1;
      r_vld[0] <= bus.oSRAM_re;
      for (int k = 1; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_fly <= r_fly + (w_next == S_W0 ? CW'(2) : CW'(0)) - CW'(w_push);
    end
  end
  always_ff @(posedge Clock) begin
    r_idx[0] <= w_idx;
    for (int k = 1; k < RD_LAT; k++) r_idx[k] <= r_idx[k-1];
    if (r_vld[RD_LAT-1] && r_idx[RD_LAT-1] == 2'd0) {r_r0, r_g0} <= w_d;
    if (w_push && r_idx[RD_LAT-1] == 2'd1) r_r1 <= w_d[7:0];
    if (w_push) r_mem[r_wp] <= w_pix;
  end
  always_ff @(posedge Clock)
    r_unf <= Reset ? 1'b0 : (r_unf || (w_take && r_cnt == '0));
  always_ff @(posedge Clock)
    if (!Reset && !w_restart) assert (!(w_push && r_cnt == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: scoreboard bench with SRAM and VGA scan models on a reduced 16x6 image
module tb_vga_pixel_fetch;
  localparam int H = 16, V = 6, HT = 24, VT = 9, LAT = 2, D = 8, NW = 3 * H * V / 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  logic [15:0] mem [256];
  logic [17:0] ash [LAT];
  logic [23:0] exp_q [$];
  always #10 clk = ~clk;
  vga_pixel_fetch_if bus ();
  vga_pixel_fetch #(.H_ACT(H), .V_ACT(V), .BASE_ADDR(18'd0), .RD_LAT(LAT), .FIFO_DEPTH(D))
    dut (.Clock(clk), .Reset(rst), .bus(bus));
  always @(posedge clk) begin
    ash[0] <= bus.oSRAM_address;
    for (int k = 1; k < LAT; k++) ash[k] <= ash[k-1];
  end
  assign bus.iSRAM_read_data = mem[ash[LAT-1][7:0]];
  function automatic logic [23:0] gold(int p);
    int k;
    k = (p / 2) * 3;
    return (p % 2 == 0) ? {mem[k], mem[k+1][15:8]} : {mem[k+1][7:0], mem[k+2]};
  endfunction
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(logic en, int x, int y);
    @(posedge clk);
    #1;
    bus.Enable = en;
    bus.iCoord_X = 10'(x);
    bus.iCoord_Y = 10'(y);
  endtask
  task automatic run_frame();
    for (int l = 0; l < VT; l++) begin
      int y;
      y = (l + V) % VT;
      for (int x = 0; x < HT; x++) begin
        step(1'b1, x, y);
        if (x < H && y < V) exp_q.push_back(gold(y * H + x));
        step(1'b0, x, y);
      end
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.Enable && bus.iCoord_X < 10'(H) && bus.iCoord_Y < 10'(V) && exp_q.size() > 0) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      check("pixel", {8'h0, bus.oRed, bus.oGreen, bus.oBlue}, {8'h0, e});
    end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int nrd, t;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0713 + 16'h5A00);
    mem[0] = 16'hAABB;
    mem[1] = 16'hCCDD;
    mem[2] = 16'hEEFF;
    bus.Enable = 1'b0;
    bus.iCoord_X = 10'(H + 2);
    bus.iCoord_Y = 10'(V + 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_re", bus.oSRAM_re, 0);
    check("rst_addr", bus.oSRAM_address, 0);
    check("rst_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 0);
    check("rst_unf", bus.oUnderflow, 0);
    rst = 1'b0;
    nrd = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.oSRAM_re) begin
        check("prefill_addr", bus.oSRAM_address, nrd);
        nrd++;
      end
    end
    check("prefill_reads", nrd, 12);
    check("prefill_re_idle", bus.oSRAM_re, 0);
    check("prefill_cnt", dut.r_cnt, D);
    check("prefill_head", {bus.oRed, bus.oGreen, bus.oBlue}, 24'hAABBCC);
    exp_q.push_back(24'hAABBCC);
    exp_q.push_back(24'hDDEEFF);
    step(1'b1, 0, 0);
    step(1'b1, 1, 0);
    step(1'b0, H + 2, V + 1);
    t = 0;
    while (!bus.oSRAM_re && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("fetch_resume", bus.oSRAM_re, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_re", bus.oSRAM_re, 0);
    check("midrst_addr", bus.oSRAM_address, 0);
    check("midrst_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_cnt", dut.r_cnt, 0);
    repeat (40) @(posedge clk);
    #1;
    check("refill_cnt", dut.r_cnt, D);
    check("refill_head", {bus.oRed, bus.oGreen, bus.oBlue}, 24'hAABBCC);
    run_frame();
    @(posedge clk);
    #1;
    check("frame1_addr", bus.oSRAM_address, NW);
    check("frame1_re", bus.oSRAM_re, 0);
    check("frame1_unf", bus.oUnderflow, 0);
    check("frame1_cnt", dut.r_cnt, 0);
    step(1'b1, 0, V);
    step(1'b0, 0, V);
    step(1'b0, 0, V);
    check("restart_fetching", bus.oSRAM_re, 1);
    step(1'b1, 0, V);
    step(1'b0, 0, V);
    check("restart_re", bus.oSRAM_re, 0);
    check("restart_addr", bus.oSRAM_address, 0);
    check("restart_cnt", dut.r_cnt, 0);
    check("restart_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 0);
    run_frame();
    @(posedge clk);
    #1;
    check("frame2_addr", bus.oSRAM_address, NW);
    check("frame2_unf", bus.oUnderflow, 0);
    step(1'b1, 3, 2);
    check("unf_rgb", {bus.oRed, bus.oGreen, bus.oBlue}, 0);
    step(1'b0, 3, 2);
    check("unf_set", bus.oUnderflow, 1);
    step(1'b1, 0, V);
    step(1'b0, 0, V);
    check("unf_sticky", bus.oUnderflow, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("unf_cleared", bus.oUnderflow, 0);
    rst = 1'b0;
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
